// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and constants for the UART receiver
// UART_RX_PARITY_EN adds the PARITY state to rx_state_e.
`ifndef WIDTH
`define WIDTH 8
`endif

package uart_pkg;

  localparam int UART_WIDTH = `WIDTH;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} rx_state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} rx_state_e;
`endif

  // Anything that is not a supported ratio falls back to 8x oversampling.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    if (p == PRESCALE_16 || p == PRESCALE_32) begin
      return p;
    end
    return PRESCALE_8;
  endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// rtl/edge_bit_counter.sv - oversampling edge counter and bit counter for the UART receiver
// Both counters hold at zero whenever enable is low.
module edge_bit_counter #(
  parameter int BIT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [5:0]       prescale,
  output logic [5:0]       edge_cnt,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             edge_wrap
);

  assign edge_wrap = enable && (edge_cnt == prescale - 6'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= '0;
    end else if (edge_wrap) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= bit_cnt + 1'b1;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive frame controller steering an external sampler and deserializer
// Define UART_RX_PARITY_EN to add the parity bit, parity_type_in and parity_error_out.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_WIDTH
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  input  logic       sampled_bit_in,
  input  logic [5:0] prescale_in,
`ifdef UART_RX_PARITY_EN
  input  logic       parity_type_in,
  output logic       parity_error_out,
`endif
  output logic       sample_en_out,
  output logic       des_en_out,
  output logic       data_valid_out,
  output logic       stop_error_out,
  output logic       busy_out
);

  localparam int CNT_W = $clog2(WIDTH + 4);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH);

  rx_state_e        state;
  logic [5:0]       prescale_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             edge_wrap;
  logic [5:0]       edge_cnt_unused;
  logic             stop_err;
`ifdef UART_RX_PARITY_EN
  logic             parity_acc;
  logic             parity_err;
`endif

  // The counter runs exactly while the sampler is enabled, so it clears in IDLE and DONE.
  edge_bit_counter #(
    .BIT_W(CNT_W)
  ) u_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (sample_en_out),
    .prescale  (prescale_q),
    .edge_cnt  (edge_cnt_unused),
    .bit_cnt   (bit_cnt),
    .edge_wrap (edge_wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      prescale_q       <= PRESCALE_8;
      stop_err         <= 1'b0;
      sample_en_out    <= 1'b0;
      des_en_out       <= 1'b0;
      data_valid_out   <= 1'b0;
      stop_error_out   <= 1'b0;
      busy_out         <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_acc       <= 1'b0;
      parity_err       <= 1'b0;
      parity_error_out <= 1'b0;
`endif
    end else begin
      des_en_out     <= 1'b0;
      data_valid_out <= 1'b0;
      stop_error_out <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error_out <= 1'b0;
`endif
      case (state)
        IDLE: begin
          stop_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
          parity_acc <= 1'b0;
          parity_err <= 1'b0;
`endif
          if (!rx_in) begin
            state         <= START;
            prescale_q    <= legal_prescale(prescale_in);
            sample_en_out <= 1'b1;
            busy_out      <= 1'b1;
          end
        end
        START: begin
          if (edge_wrap) begin
            if (sampled_bit_in) begin
              // Start bit did not hold low through the bit: treat it as line noise.
              state         <= IDLE;
              sample_en_out <= 1'b0;
              busy_out      <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (edge_wrap) begin
            des_en_out <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_acc <= parity_acc ^ sampled_bit_in;
            if (bit_cnt == LAST_DATA) begin
              state <= PARITY;
            end
`else
            if (bit_cnt == LAST_DATA) begin
              state <= STOP;
            end
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (edge_wrap) begin
            parity_err <= sampled_bit_in != (parity_acc ^ parity_type_in);
            state      <= STOP;
          end
        end
`endif
        STOP: begin
          if (edge_wrap) begin
            stop_err       <= !sampled_bit_in;
            stop_error_out <= !sampled_bit_in;
            sample_en_out  <= 1'b0;
            state          <= DONE;
          end
        end
        DONE: begin
`ifdef UART_RX_PARITY_EN
          data_valid_out   <= !parity_err && !stop_err;
          parity_error_out <= parity_err;
`else
          data_valid_out   <= !stop_err;
`endif
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state         <= IDLE;
          sample_en_out <= 1'b0;
          busy_out      <= 1'b0;
        end
      endcase
    end
  end

endmodule
